// File: rtl/flp_shlnorm_pkg.sv
// Shared definitions for the flp_shlnorm left shifter / normaliser.
// Provides the mode encodings and a constant clog2 used to size the shift fields.
package flp_shlnorm_pkg;

    typedef enum logic {
        FLP_SHL_MODE_SHAMT = 1'b0,
        FLP_SHL_MODE_NORM  = 1'b1
    } flp_shl_mode_e;

    function automatic int unsigned flp_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/flp_shlnorm_if.sv
// Valid/ready stream bundle between the mantissa adder, the shifter and the pack stage.
// The slave side is the shifter itself.
interface flp_shlnorm_if #(
    parameter int unsigned INWIDTH  = 64,
    parameter int unsigned OUTWIDTH = 32,
    parameter int unsigned SHW      = 6
);
    logic [INWIDTH-1:0]  i_data;
    logic [SHW-1:0]      i_shamt;
    logic                i_mode;
    logic                i_valid;
    logic                o_ready;
    logic [OUTWIDTH-1:0] o_data;
    logic [SHW-1:0]      o_shamt;
    logic                o_zero;
    logic                o_lost;
    logic                o_valid;
    logic                i_ready;

    modport master (
        output i_data, i_shamt, i_mode, i_valid, i_ready,
        input  o_ready, o_data, o_shamt, o_zero, o_lost, o_valid
    );

    modport slave (
        input  i_data, i_shamt, i_mode, i_valid, i_ready,
        output o_ready, o_data, o_shamt, o_zero, o_lost, o_valid
    );
endinterface

// File: rtl/flp_shlnorm_lzc.sv
// Combinational leading-zero counter; count is 0 when the input is all zero.
module flp_lzc
    import flp_shlnorm_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CW = (WIDTH > 1) ? flp_clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count,
    output logic             zero
);

    // Scanning upward lets the highest set bit win the final assignment.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CW'(WIDTH - 1 - i);
            end
        end
        zero = ~|data;
    end

endmodule

// File: rtl/flp_shlnorm.sv
// Two-stage variable left shifter with normalise mode for the FP datapath.
// Stage 1 captures operand, shift amount and flags; stage 2 holds the shifted result.
module flp_shlnorm
    import flp_shlnorm_pkg::*;
#(
    parameter int unsigned INWIDTH  = 64,
    parameter int unsigned OUTWIDTH = 32,
    parameter int unsigned SHW      = flp_clog2(OUTWIDTH + 1)
) (
    input logic        clk,
    input logic        nrst,
    flp_shlnorm_if.slave bus
);

    localparam int unsigned CW = (OUTWIDTH > 1) ? flp_clog2(OUTWIDTH) : 1;
    localparam logic [SHW-1:0] OUT_LIM = SHW'(OUTWIDTH);

    logic [OUTWIDTH-1:0] in_low;
    logic                in_upper;
    logic [CW-1:0]       lzc_count;
    logic                lzc_zero;
    logic [SHW-1:0]      s_in;

    logic                rdy_en;
    logic                ready;
    logic                accept;
    logic                s2_load;

    logic                s1_valid;
    logic [OUTWIDTH-1:0] s1_data;
    logic [SHW-1:0]      s1_shamt;
    logic                s1_zero;
    logic                s1_upper;

    logic [2*OUTWIDTH-1:0] wide;
    logic [OUTWIDTH-1:0]   shifted;
    logic                  spill;

    logic                s2_valid;
    logic [OUTWIDTH-1:0] s2_data;
    logic [SHW-1:0]      s2_shamt;
    logic                s2_zero;
    logic                s2_lost;

    assign in_low = bus.i_data[OUTWIDTH-1:0];

    generate
        if (INWIDTH > OUTWIDTH) begin : g_upper
            assign in_upper = |bus.i_data[INWIDTH-1:OUTWIDTH];
        end else begin : g_no_upper
            assign in_upper = 1'b0;
        end
    endgenerate

    flp_lzc #(.WIDTH(OUTWIDTH)) u_lzc (
        .data  (in_low),
        .count (lzc_count),
        .zero  (lzc_zero)
    );

    always_comb begin
        s_in = bus.i_shamt;
        if (flp_shl_mode_e'(bus.i_mode) == FLP_SHL_MODE_NORM) begin
            s_in = lzc_zero ? '0 : SHW'(lzc_count);
        end
    end

    assign s2_load = !s2_valid | bus.i_ready;
    assign ready   = rdy_en & (!s1_valid | s2_load);
    assign accept  = bus.i_valid & ready;

    // Stage 1: rdy_en keeps o_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdy_en   <= 1'b0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shamt <= '0;
            s1_zero  <= 1'b0;
            s1_upper <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (ready) begin
                s1_valid <= bus.i_valid;
            end
            if (accept) begin
                s1_data  <= in_low;
                s1_shamt <= s_in;
                s1_zero  <= lzc_zero;
                s1_upper <= in_upper;
            end
        end
    end

    // Double-width shift exposes the spilled bits; shifts of OUTWIDTH or more spill everything.
    always_comb begin
        wide    = {{OUTWIDTH{1'b0}}, s1_data} << s1_shamt;
        shifted = wide[OUTWIDTH-1:0];
        spill   = |wide[2*OUTWIDTH-1:OUTWIDTH];
        if (s1_shamt >= OUT_LIM) begin
            shifted = '0;
            spill   = |s1_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_shamt <= '0;
            s2_zero  <= 1'b0;
            s2_lost  <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
            end
            if (s2_load & s1_valid) begin
                s2_data  <= shifted;
                s2_shamt <= s1_shamt;
                s2_zero  <= s1_zero;
                s2_lost  <= s1_upper | spill;
            end
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = s2_valid;
    assign bus.o_data  = s2_data;
    assign bus.o_shamt = s2_shamt;
    assign bus.o_zero  = s2_zero;
    assign bus.o_lost  = s2_lost;

endmodule
